// File: rtl/axis_frame_monitor.sv
// Passive multi-channel AXI-stream frame monitor with AXI-lite counter access.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mon_axis_t*           tapped per-channel stream signals (ch0 in LSBs), observed only
//   led                   first payload byte of the latest LED_CH frame
//   s_axil_*              AXI-lite slave: CTRL/INFO and per-channel counter registers
module axis_frame_monitor #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned N_CH            = 4,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned LED_CH          = 0,
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned AXIL_ADDR_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CH*DATA_WIDTH-1:0]     mon_axis_tdata,
    input  logic [N_CH*KEEP_WIDTH-1:0]     mon_axis_tkeep,
    input  logic [N_CH-1:0]                mon_axis_tvalid,
    input  logic [N_CH-1:0]                mon_axis_tready,
    input  logic [N_CH-1:0]                mon_axis_tlast,
    output logic [7:0]                     led,
    input  logic [AXIL_ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready
);

    localparam int unsigned POP_W = $clog2(KEEP_WIDTH + 1);
    localparam int unsigned LEN_W = 16;
    localparam int unsigned AW    = AXIL_ADDR_WIDTH;
    localparam int unsigned DW    = AXIL_DATA_WIDTH;

    function automatic logic [POP_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [POP_W-1:0] n;
        n = '0;
        for (int b = 0; b < int'(KEEP_WIDTH); b++) n = n + POP_W'(k[b]);
        return n;
    endfunction

    logic [CNT_WIDTH-1:0] frames_q [N_CH], frames_d [N_CH];
    logic [CNT_WIDTH-1:0] bytes_q  [N_CH], bytes_d  [N_CH];
    logic [31:0]          first_q  [N_CH], first_d  [N_CH];
    logic [LEN_W-1:0]     max_q    [N_CH], max_d    [N_CH];
    logic [LEN_W-1:0]     len_q    [N_CH], len_d    [N_CH];
    logic [N_CH-1:0]      in_frame_q, in_frame_d;
    logic [7:0]           led_q, led_d;
    logic                 freeze_q, freeze_d;
    logic                 awready_q, awready_d, bvalid_q, bvalid_d;
    logic                 arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]        rdata_q, rdata_d, rd_mux;

    logic [N_CH-1:0]      accept;
    logic [POP_W-1:0]     pop      [N_CH];
    logic [LEN_W-1:0]     len_sat  [N_CH];
    logic                 wr_fire, rd_fire, ctrl_wr, clear;

    // Per-channel beat acceptance, byte count and saturated running length
    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        logic [LEN_W:0] len_sum;
        assign accept[g]  = mon_axis_tvalid[g] & mon_axis_tready[g];
        assign pop[g]     = popcount(mon_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH]);
        assign len_sum    = {1'b0, len_q[g]} + (LEN_W+1)'(pop[g]);
        assign len_sat[g] = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
    end

    // AXI-lite handshake decode; CLEAR acts on the same edge as the write handshake
    assign wr_fire = awready_q & s_axil_awvalid & s_axil_wvalid;
    assign rd_fire = arready_q & s_axil_arvalid;
    assign ctrl_wr = wr_fire && (s_axil_awaddr[AW-1:2] == (AW-2)'(0))
                     && (s_axil_wstrb == {(DW/8){1'b1}});
    assign clear   = ctrl_wr & s_axil_wdata[0];

    // Frame tracking and counter next-state
    always_comb begin
        frames_d   = frames_q;
        bytes_d    = bytes_q;
        first_d    = first_q;
        max_d      = max_q;
        len_d      = len_q;
        in_frame_d = in_frame_q;
        led_d      = led_q;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (accept[c]) in_frame_d[c] = ~mon_axis_tlast[c];
            if (clear) begin
                frames_d[c] = '0;
                bytes_d[c]  = '0;
                first_d[c]  = '0;
                max_d[c]    = '0;
                len_d[c]    = '0;
            end else if (accept[c]) begin
                len_d[c] = mon_axis_tlast[c] ? '0 : len_sat[c];
                if (!freeze_q) begin
                    bytes_d[c] = bytes_q[c] + CNT_WIDTH'(pop[c]);
                    if (!in_frame_q[c]) first_d[c] = mon_axis_tdata[c*DATA_WIDTH +: 32];
                    if (mon_axis_tlast[c]) begin
                        frames_d[c] = frames_q[c] + CNT_WIDTH'(1);
                        if (len_sat[c] > max_q[c]) max_d[c] = len_sat[c];
                    end
                end
            end
        end
        // LED follows the first byte of each LED_CH frame regardless of CLEAR/FREEZE
        if (accept[LED_CH] && !in_frame_q[LED_CH])
            led_d = mon_axis_tdata[LED_CH*DATA_WIDTH +: 8];
    end

    // Register read mux, sampled on the read handshake
    always_comb begin
        rd_mux = '0;
        if (s_axil_araddr[AW-1:2] == (AW-2)'(0)) begin
            rd_mux = DW'({freeze_q, 1'b0});
        end else if (s_axil_araddr[AW-1:2] == (AW-2)'(1)) begin
            rd_mux = DW'({8'd0, 8'(N_CH), 16'(DATA_WIDTH)});
        end else if (s_axil_araddr[AW-1:8] == (AW-8)'(1)) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (s_axil_araddr[7:4] == 4'(c)) begin
                    case (s_axil_araddr[3:2])
                        2'd0:    rd_mux = DW'(frames_q[c]);
                        2'd1:    rd_mux = DW'(bytes_q[c]);
                        2'd2:    rd_mux = DW'(first_q[c]);
                        default: rd_mux = DW'(max_q[c]);
                    endcase
                end
            end
        end
    end

    // AXI-lite channel next-state
    always_comb begin
        freeze_d  = ctrl_wr ? s_axil_wdata[1] : freeze_q;
        awready_d = s_axil_awvalid & s_axil_wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = wr_fire ? 1'b1 : (s_axil_bready ? 1'b0 : bvalid_q);
        arready_d = s_axil_arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rd_fire ? 1'b1 : (s_axil_rready ? 1'b0 : rvalid_q);
        rdata_d   = rd_fire ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q   <= '{default: '0};
            bytes_q    <= '{default: '0};
            first_q    <= '{default: '0};
            max_q      <= '{default: '0};
            len_q      <= '{default: '0};
            in_frame_q <= '0;
            led_q      <= '0;
            freeze_q   <= 1'b0;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            frames_q   <= frames_d;
            bytes_q    <= bytes_d;
            first_q    <= first_d;
            max_q      <= max_d;
            len_q      <= len_d;
            in_frame_q <= in_frame_d;
            led_q      <= led_d;
            freeze_q   <= freeze_d;
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign led            = led_q;
    assign s_axil_awready = awready_q;
    assign s_axil_wready  = awready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;

    // Bits of the tap and address buses that carry nothing this block needs
    logic unused_bits;
    assign unused_bits = &{1'b0, mon_axis_tdata, s_axil_wdata,
                           s_axil_awaddr[1:0], s_axil_araddr[1:0]};

endmodule

// File: tb/tb_axis_frame_monitor.sv
module tb_axis_frame_monitor;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int NCH = 4;
    localparam int AW  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0]       td [NCH];
    logic [KW-1:0]       tk [NCH];
    logic [NCH-1:0]      tv, tr, tl;
    logic [NCH*DW-1:0]   tdata;
    logic [NCH*KW-1:0]   tkeep;
    logic [7:0]          led;
    logic [AW-1:0]       awaddr, araddr;
    logic                awvalid, awready, wvalid, wready, bvalid, bready;
    logic                arvalid, arready, rvalid, rready;
    logic [31:0]         wdata, rdata;
    logic [3:0]          wstrb;
    logic [1:0]          bresp, rresp;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            tdata[c*DW +: DW] = td[c];
            tkeep[c*KW +: KW] = tk[c];
        end
    end

    axis_frame_monitor dut (
        .clk(clk), .rst(rst),
        .mon_axis_tdata(tdata), .mon_axis_tkeep(tkeep), .mon_axis_tvalid(tv),
        .mon_axis_tready(tr), .mon_axis_tlast(tl), .led(led),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready), .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
        .s_axil_bready(bready), .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_start(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        check("awready", 32'(awready), 32'd1);
        check("wready", 32'(wready), 32'd1);
    endtask

    task automatic wr_finish();
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
        tick();
        bready = 1'b0;
    endtask

    task automatic axil_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_start(a, d, s);
        tick();
        wr_finish();
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        if (!arready) check({tag, "_arready"}, 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0; rready = 1'b1;
        if (!rvalid) check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check(tag, rdata, exp);
        tick();
        rready = 1'b0;
    endtask

    task automatic send_beat(input int ch, input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic last);
        td[ch] = d; tk[ch] = k; tl[ch] = last; tv[ch] = 1'b1; tr[ch] = 1'b1;
        tick();
        tv[ch] = 1'b0; tl[ch] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int c = 0; c < NCH; c++) begin td[c] = '0; tk[c] = '0; end
        tv = '0; tr = '0; tl = '0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();
        check("rst_led", 32'(led), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();
        rd_check("rst_frames0", 16'h0100, 32'd0);

        // 1: ch0 three-beat frame, 8+8+4 bytes
        send_beat(0, 64'h01020304050607A5, 8'hFF, 1'b0);
        send_beat(0, 64'h1111111111111111, 8'hFF, 1'b0);
        send_beat(0, 64'h2222222222222222, 8'h0F, 1'b1);
        rd_check("t1_frames", 16'h0100, 32'd1);
        rd_check("t1_bytes", 16'h0104, 32'd20);
        rd_check("t1_first", 16'h0108, 32'h050607A5);
        rd_check("t1_max", 16'h010C, 32'd20);
        check("t1_led", 32'(led), 32'hA5);

        // 2: ch1 stalled beat, then accepted single-beat frame
        td[1] = 64'h00000000DEADBE01; tk[1] = 8'h01; tl[1] = 1'b1; tv[1] = 1'b1; tr[1] = 1'b0;
        repeat (10) tick();
        rd_check("t2_stall_frames", 16'h0110, 32'd0);
        rd_check("t2_stall_bytes", 16'h0114, 32'd0);
        tr[1] = 1'b1;
        tick();
        tv[1] = 1'b0; tl[1] = 1'b0; tr[1] = 1'b0;
        rd_check("t2_frames", 16'h0110, 32'd1);
        rd_check("t2_bytes", 16'h0114, 32'd1);
        rd_check("t2_first", 16'h0118, 32'hDEADBE01);
        rd_check("t2_max", 16'h011C, 32'd1);
        check("t2_led", 32'(led), 32'hA5);

        // 3: clear, then 100 x 64-byte frames on all channels at once
        axil_write(16'h0000, 32'd1, 4'hF);
        rd_check("t3_clr_frames0", 16'h0100, 32'd0);
        for (int f = 0; f < 100; f++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < NCH; c++) begin
                    td[c] = {40'd0, 8'(c), 8'(b), 8'(f)};
                    tk[c] = 8'hFF;
                end
                tl = (b == 7) ? 4'hF : 4'h0;
                tv = 4'hF; tr = 4'hF;
                tick();
            end
        end
        tv = '0; tl = '0; tr = '0;
        for (int c = 0; c < NCH; c++) begin
            rd_check("t3_frames", 16'(16'h0100 + c * 16'h10), 32'd100);
            rd_check("t3_bytes", 16'(16'h0104 + c * 16'h10), 32'd6400);
            rd_check("t3_max", 16'(16'h010C + c * 16'h10), 32'd64);
        end
        rd_check("t3_first3", 16'h0138, 32'h00030063);
        check("t3_led", 32'(led), 32'h63);

        // 4: CLEAR coincident with ch0 tlast beat
        send_beat(0, 64'h000000000000005A, 8'hFF, 1'b0);
        check("t4_led_pre", 32'(led), 32'h5A);
        wr_start(16'h0000, 32'd1, 4'hF);
        td[0] = 64'h0; tk[0] = 8'hFF; tl[0] = 1'b1; tv[0] = 1'b1; tr[0] = 1'b1;
        tick();
        tv[0] = 1'b0; tl[0] = 1'b0;
        wr_finish();
        rd_check("t4_clr_frames", 16'h0100, 32'd0);
        rd_check("t4_clr_bytes", 16'h0104, 32'd0);
        rd_check("t4_clr_first", 16'h0108, 32'd0);
        rd_check("t4_clr_max", 16'h010C, 32'd0);
        rd_check("t4_clr_frames1", 16'h0110, 32'd0);
        check("t4_led_hold", 32'(led), 32'h5A);
        send_beat(0, 64'hFFFFFFFF1234563C, 8'h0F, 1'b1);
        rd_check("t4_frames", 16'h0100, 32'd1);
        rd_check("t4_bytes", 16'h0104, 32'd4);
        rd_check("t4_first", 16'h0108, 32'h1234563C);
        rd_check("t4_max", 16'h010C, 32'd4);
        check("t4_led", 32'(led), 32'h3C);

        // 5: clear+freeze, frozen traffic, partial strobe ignored, unfreeze
        axil_write(16'h0000, 32'd3, 4'hF);
        rd_check("t5_ctrl_frz", 16'h0000, 32'd2);
        for (int k = 0; k < 5; k++) begin
            send_beat(0, 64'(8'h40 + 8'(k)), 8'hFF, 1'b0);
            send_beat(0, 64'h0, 8'hFF, 1'b1);
        end
        rd_check("t5_frz_frames", 16'h0100, 32'd0);
        rd_check("t5_frz_bytes", 16'h0104, 32'd0);
        rd_check("t5_frz_first", 16'h0108, 32'd0);
        rd_check("t5_frz_max", 16'h010C, 32'd0);
        check("t5_frz_led", 32'(led), 32'h44);
        axil_write(16'h0000, 32'd0, 4'h3);
        rd_check("t5_ctrl_partial", 16'h0000, 32'd2);
        axil_write(16'h0000, 32'd0, 4'hF);
        for (int k = 0; k < 2; k++) begin
            send_beat(0, 64'(32'hAABB0050 + 32'(k)), 8'hFF, 1'b0);
            send_beat(0, 64'h0, 8'hFF, 1'b1);
        end
        rd_check("t5_frames", 16'h0100, 32'd2);
        rd_check("t5_bytes", 16'h0104, 32'd32);
        rd_check("t5_first", 16'h0108, 32'hAABB0051);
        rd_check("t5_max", 16'h010C, 32'd16);
        rd_check("t5_ctrl", 16'h0000, 32'd0);
        rd_check("t5_info", 16'h0004, 32'h00040040);

        // 6: reset in the middle of a ch2 frame, then the tail of it
        send_beat(2, 64'h0000000000000001, 8'hFF, 1'b0);
        send_beat(2, 64'h0000000000000002, 8'hFF, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("t6_rst_led", 32'(led), 32'd0);
        send_beat(2, 64'h000000000000C003, 8'hFF, 1'b0);
        send_beat(2, 64'h0000000000000004, 8'hFF, 1'b1);
        rd_check("t6_frames", 16'h0120, 32'd1);
        rd_check("t6_bytes", 16'h0124, 32'd16);
        rd_check("t6_first", 16'h0128, 32'h0000C003);
        rd_check("t6_max", 16'h012C, 32'd16);
        rd_check("t6_frames0", 16'h0100, 32'd0);
        rd_check("t6_unmapped", 16'h0200, 32'd0);
        rd_check("t6_ch4", 16'h0140, 32'd0);
        check("t6_rresp", 32'(rresp), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
